// File: rtl/mem_sum_if.sv
// mem_sum_if: command port and data-memory port bundle for mem_sum_engine
interface mem_sum_if #(parameter int CNT_W = 8);
  logic start;
  logic [31:0] base;
  logic [CNT_W-1:0] count;
  logic [31:0] dest;
  logic busy;
  logic done;
  logic ovf;
  logic [31:0] result;
  logic [31:0] mem_a;
  logic [31:0] mem_di;
  logic [31:0] mem_do;
  logic mem_we;
  modport master (output start, base, count, dest, mem_do,
                  input busy, done, result, ovf, mem_a, mem_di, mem_we);
  modport slave (input start, base, count, dest, mem_do,
                 output busy, done, result, ovf, mem_a, mem_di, mem_we);
endinterface

// File: rtl/mem_sum_engine.sv
// mem_sum_engine: sums a run of memory words and writes the total to a destination address
// MEM_SUM_OVF_EN enables the sticky carry-out flag; otherwise ovf is tied low.
module mem_sum_engine #(
  parameter int ADDR_STEP = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  mem_sum_if.slave b
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0] state;
  logic [31:0] base_q, dest_q, acc, result_q;
  logic [CNT_W-1:0] count_q, idx;
  logic accept;
  assign accept = state == IDLE && b.start;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      base_q <= '0;
      dest_q <= '0;
      count_q <= '0;
      acc <= '0;
      idx <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: if (b.start) begin
          base_q <= b.base;
          count_q <= b.count;
          dest_q <= b.dest;
          acc <= '0;
          idx <= '0;
          state <= b.count != '0 ? READ : WRITE;
        end
        READ: begin
          acc <= acc + b.mem_do;
          idx <= idx + 1'b1;
          if (idx == count_q - 1'b1) state <= WRITE;
        end
        WRITE: begin
          result_q <= acc;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef MEM_SUM_OVF_EN
  logic ovf_q;
  logic carry;
  // a + b overflows 32 bits exactly when b exceeds the one's complement of a
  assign carry = b.mem_do > ~acc;
  always_ff @(posedge clk) begin
    if (rst || accept) ovf_q <= 1'b0;
    else if (state == READ && carry) ovf_q <= 1'b1;
  end
  assign b.ovf = ovf_q;
`else
  assign b.ovf = 1'b0;
`endif
  assign b.busy = state != IDLE;
  assign b.done = state == DONE;
  assign b.mem_we = state == WRITE;
  assign b.mem_a = state == READ ? base_q + 32'(idx) * 32'(ADDR_STEP) : state == WRITE ? dest_q : '0;
  assign b.mem_di = state == WRITE ? acc : '0;
  assign b.result = result_q;
endmodule

// File: tb/tb_mem_sum_engine.sv
// tb_mem_sum_engine: directed commands with a done-driven scoreboard monitor
module tb_mem_sum_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int vectors = 0;
  int errs = 0;
  int we_cnt = 0;
  int we_total = 0;
  int n_done = 0;
  int n_exp = 0;
  logic [31:0] mem [0:63];
  typedef struct {
    logic [31:0] sum;
    logic [31:0] dest;
    logic ovf;
    int acc_cyc;
    int n;
  } exp_t;
  exp_t q[$];
`ifdef MEM_SUM_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif
  mem_sum_if #(.CNT_W(8)) i ();
  mem_sum_engine #(.ADDR_STEP(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .b(i.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb i.mem_do = mem[i.mem_a[7:2]];
  always @(posedge clk) if (i.mem_we) mem[i.mem_a[7:2]] <= i.mem_di;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (i.mem_we) begin
      we_cnt++;
      we_total++;
    end
    if (i.done) begin
      n_done++;
      if (q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("result", i.result, e.sum);
        chk("mem_dest", mem[e.dest[7:2]], e.sum);
        chk("ovf", {31'd0, i.ovf}, {31'd0, e.ovf});
        chk("done_latency", 32'(cyc - e.acc_cyc + 1), 32'(e.n + 2));
        chk("we_cycles", 32'(we_cnt), 32'd1);
      end
      we_cnt = 0;
    end
  end
  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (i.busy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) chk("idle_timeout", 32'd1, 32'd0);
  endtask
  task automatic issue(input logic [31:0] bs, input logic [7:0] n, input logic [31:0] ds,
                       input logic [31:0] sum, input logic eo, input bit hold, input bit track,
                       output int acc_c);
    int t = 0;
    @(negedge clk);
    i.base = bs;
    i.count = n;
    i.dest = ds;
    i.start = 1'b1;
    while (i.busy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    acc_c = cyc;
    if (track) begin
      q.push_back('{sum, ds, eo, acc_c, int'(n)});
      n_exp++;
    end
    if (!hold) i.start = 1'b0;
  endtask
  initial begin
    int a0, a1, wsnap;
    for (int k = 0; k < 64; k++) mem[k] = 32'h0;
    mem[6'h14] = 32'ha3;
    mem[6'h15] = 32'h27;
    mem[6'h16] = 32'h79;
    mem[6'h17] = 32'h115;
    mem[6'h04] = 32'hdead;
    mem[6'h08] = 32'hffffffff;
    mem[6'h09] = 32'h2;
    mem[6'h1a] = 32'h1234;
    i.start = 1'b0;
    i.base = '0;
    i.count = '0;
    i.dest = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, i.busy}, 32'd0);
    chk("rst_done", {31'd0, i.done}, 32'd0);
    chk("rst_result", i.result, 32'd0);
    chk("rst_ovf", {31'd0, i.ovf}, 32'd0);
    chk("rst_we", {31'd0, i.mem_we}, 32'd0);
    chk("rst_mem_a", i.mem_a, 32'd0);
    chk("rst_mem_di", i.mem_di, 32'd0);
    rst = 1'b0;
    issue(32'h50, 8'd4, 32'h60, 32'h258, 1'b0, 1'b0, 1'b1, a0);
    wait_idle();
    issue(32'h0, 8'd0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, a0);
    wait_idle();
    issue(32'h20, 8'd2, 32'h28, 32'h1, OVF_ON, 1'b0, 1'b1, a0);
    wait_idle();
    issue(32'h50, 8'd4, 32'h64, 32'h258, 1'b0, 1'b0, 1'b1, a0);
    repeat (2) @(negedge clk);
    i.start = 1'b1;
    i.base = 32'h20;
    i.count = 8'd1;
    i.dest = 32'h2c;
    @(negedge clk);
    i.start = 1'b0;
    wait_idle();
    chk("ignored_no_write", mem[6'h0b], 32'h0);
    wsnap = we_total;
    issue(32'h50, 8'd4, 32'h68, 32'h0, 1'b0, 1'b0, 1'b0, a0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, i.busy}, 32'd0);
    chk("abort_result", i.result, 32'd0);
    chk("abort_ovf", {31'd0, i.ovf}, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_mem_dest", mem[6'h1a], 32'h1234);
    chk("abort_no_we", 32'(we_total - wsnap), 32'd0);
    issue(32'h54, 8'd3, 32'h6c, 32'h1b5, 1'b0, 1'b0, 1'b1, a0);
    wait_idle();
    issue(32'h58, 8'd2, 32'h70, 32'h18e, 1'b0, 1'b1, 1'b1, a0);
    issue(32'h50, 8'd1, 32'h74, 32'ha3, 1'b0, 1'b0, 1'b1, a1);
    chk("b2b_gap", 32'(a1 - a0), 32'd5);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("done_pulses", 32'(n_done), 32'(n_exp));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/mem_sum_engine.md
# mem_sum_engine

Bus initiator for the single-port data memory. On a start command it reads a run of consecutive words beginning at a base address, accumulates them into a 32-bit sum, and writes the sum back to a destination address. It sits between the control path and the data memory port and owns the address, write-data and write-enable lines while busy; the memory returns read data combinationally in the same cycle.

## Interface
- ADDR_STEP, 4: address increment between consecutive words (byte-addressed stride).
- CNT_W, 8: width of the word-count input and internal index.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- base  in  32  first source address.
- count  in  CNT_W  number of words to sum (0 allowed).
- dest  in  32  address receiving the sum.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when the sum has been written.
- result  out  32  last written sum; held until the next accepted start.
- ovf  out  1  sticky carry-out flag for the current command (see Configuration).
- mem_a  out  32  memory address.
- mem_di  out  32  memory write data.
- mem_we  out  1  memory write enable.
- mem_do  in  32  memory read data, valid combinationally from mem_a.

## Operation
- Reset is synchronous and active-high on clk; the clock and reset ports are named clk and rst.
- States: IDLE, READ, WRITE, DONE. Registered state; all outputs decoded from registers.
- IDLE: busy=0, mem_we=0, mem_a=0, mem_di=0. On start=1: latch base, count, dest; acc<=0, idx<=0, ovf<=0; go READ if count!=0, else WRITE.
- READ: mem_a = base_q + idx*ADDR_STEP (32-bit, wraps modulo 2^32). Each edge: acc <= acc + mem_do (modulo 2^32), idx <= idx+1; after the edge where idx == count_q-1, go WRITE.
- WRITE: mem_a=dest_q, mem_di=acc, mem_we=1 for exactly one cycle; result <= acc at the edge; go DONE.
- DONE: done=1 for one cycle; go IDLE. start ignored here.
- start while busy is ignored; inputs base/count/dest may change freely after acceptance.
- mem_we is never high outside WRITE; mem_di is 0 outside WRITE.
- Reset values: state IDLE, busy 0, done 0, result 0, ovf 0, mem_a 0, mem_di 0, mem_we 0, acc 0, idx 0.
- Reset mid-operation: next edge returns to IDLE; no write issued, result and ovf cleared.

## Timing
- Start sampled at edge E0. count=N>0: READ during cycles E0..E0+N, WRITE cycle after E0+N, done high the cycle after E0+N+1, IDLE after E0+N+2.
- Accept-to-done latency: N+2 cycles; N=0: 2 cycles (WRITE then DONE).
- Next start accepted at earliest the edge after done falls (N+3 cycles between accepted starts).
- count=2^CNT_W-1 is the maximum run; no truncation of idx.

## Configuration
- MEM_SUM_OVF_EN defined: each READ addition computes a 33-bit sum; if bit 32 set, ovf <= 1 (sticky until next accepted start or reset). ovf valid from DONE onward.
- Undefined: no carry logic; ovf tied to 0. Sum behaviour identical in both builds.

## Test plan
- Memory 0x50=0xa3, 0x54=0x27, 0x58=0x79, 0x5c=0x115; start base=0x50 count=4 dest=0x60 -> mem[0x60]=0x258, result=0x258, done exactly 6 cycles after accept edge, mem_we high exactly one cycle.
- count=0, dest=0x10 -> mem[0x10]=0, done 2 cycles after accept, no read-state cycles.
- Words 0xFFFFFFFF, 0x2 (count=2): result=0x1; ovf=1 with MEM_SUM_OVF_EN, ovf=0 without.
- Pulse start with different base during READ -> ignored; result matches first command, single done pulse.
- Assert rst during READ of a 4-word command -> IDLE next edge, busy=0, result=0, no write to dest; new command afterward completes correctly.
- Back-to-back: second start held high through DONE -> accepted on the first IDLE edge; both sums correct, two distinct done pulses.
